// File: rtl/riscv_csr_writeback_if.sv
// riscv_csr_writeback_if
//   Bundles the E1 CSR result, the E2 LSU fault and interrupt inputs, and the
//   csr_writeback_* / rd / squash outputs of riscv_csr_writeback.
//   slave  : the writeback block (consumes E1/E2 inputs, drives results)
//   master : the surrounding pipeline (drives E1/E2 inputs, consumes results)
interface riscv_csr_writeback_if;
    logic        opcode_valid_e1_i;
    logic [31:0] opcode_opcode_e1_i;
    logic [31:0] opcode_pc_e1_i;
    logic [31:0] csr_result_e1_value_i;
    logic        csr_result_e1_write_i;
    logic [31:0] csr_result_e1_wdata_i;
    logic [5:0]  csr_result_e1_exception_i;
    logic [5:0]  lsu_exception_e2_i;
    logic [31:0] lsu_addr_e2_i;
    logic        take_interrupt_i;
    logic        stall_i;

    logic        csr_writeback_write_o;
    logic [11:0] csr_writeback_waddr_o;
    logic [31:0] csr_writeback_wdata_o;
    logic [5:0]  csr_writeback_exception_o;
    logic [31:0] csr_writeback_exception_pc_o;
    logic [31:0] csr_writeback_exception_addr_o;
    logic        writeback_valid_o;
    logic [31:0] writeback_value_o;
    logic        squash_o;
    logic        interrupt_inhibit_o;

    modport slave (
        input  opcode_valid_e1_i, opcode_opcode_e1_i, opcode_pc_e1_i,
               csr_result_e1_value_i, csr_result_e1_write_i, csr_result_e1_wdata_i,
               csr_result_e1_exception_i, lsu_exception_e2_i, lsu_addr_e2_i,
               take_interrupt_i, stall_i,
        output csr_writeback_write_o, csr_writeback_waddr_o, csr_writeback_wdata_o,
               csr_writeback_exception_o, csr_writeback_exception_pc_o,
               csr_writeback_exception_addr_o, writeback_valid_o, writeback_value_o,
               squash_o, interrupt_inhibit_o
    );

    modport master (
        output opcode_valid_e1_i, opcode_opcode_e1_i, opcode_pc_e1_i,
               csr_result_e1_value_i, csr_result_e1_write_i, csr_result_e1_wdata_i,
               csr_result_e1_exception_i, lsu_exception_e2_i, lsu_addr_e2_i,
               take_interrupt_i, stall_i,
        input  csr_writeback_write_o, csr_writeback_waddr_o, csr_writeback_wdata_o,
               csr_writeback_exception_o, csr_writeback_exception_pc_o,
               csr_writeback_exception_addr_o, writeback_valid_o, writeback_value_o,
               squash_o, interrupt_inhibit_o
    );
endinterface

// File: rtl/riscv_csr_writeback.sv
// riscv_csr_writeback
//   Carries registered E1 CSR results through E2 and WB, merges E2 LSU faults and
//   pending interrupts, and decodes the WB register into the CSR commit/trap
//   bundle, rd writeback, pipeline squash and interrupt_inhibit.
// Ports
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : riscv_csr_writeback_if.slave (E1/E2 inputs, csr_writeback_*/rd outputs)
// Configuration
//   RISCV_CSR_WB_TVAL_EN : when defined, an illegal instruction reports the
//   captured value (faulting opcode) as exception_addr; otherwise 0.
module riscv_csr_writeback (
    input  logic                   clk_i,
    input  logic                   rst_i,
    riscv_csr_writeback_if.slave   bus
);
    localparam logic [5:0] EXC_MISALIGNED_FETCH = 6'h10;
    localparam logic [5:0] EXC_FAULT_FETCH      = 6'h11;
    localparam logic [5:0] EXC_ILLEGAL          = 6'h12;
    localparam logic [5:0] EXC_PAGE_FAULT_INST  = 6'h1c;
    localparam logic [5:0] EXC_INTERRUPT        = 6'h20;
    localparam logic [5:0] EXC_FENCE            = 6'h34;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [11:0] waddr;
        logic [31:0] value;
        logic        write;
        logic [31:0] wdata;
        logic [5:0]  exc;
    } e2_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [11:0] waddr;
        logic [31:0] value;
        logic        write;
        logic [31:0] wdata;
        logic [5:0]  exc;
        logic [31:0] addr;
    } wb_t;

    e2_t         e2_q, e2_d;
    wb_t         wb_q, wb_d;
    logic        squash;
    logic [5:0]  exc_m;
    logic [31:0] addr_m;
    logic        write_m;
    logic        e2_fetch_fault;

    assign squash = wb_q.valid & (wb_q.exc != 6'd0);

    assign e2_fetch_fault = (e2_q.exc == EXC_MISALIGNED_FETCH) |
                            (e2_q.exc == EXC_FAULT_FETCH) |
                            (e2_q.exc == EXC_PAGE_FAULT_INST);

    // E2 next state: squash kills E2 and refuses E1 even under stall.
    always_comb begin
        e2_d = e2_q;
        if (squash) begin
            e2_d = '0;
        end else if (!bus.stall_i) begin
            e2_d = '0;
            if (bus.opcode_valid_e1_i) begin
                e2_d.valid = 1'b1;
                e2_d.pc    = bus.opcode_pc_e1_i;
                e2_d.waddr = bus.opcode_opcode_e1_i[31:20];
                e2_d.value = bus.csr_result_e1_value_i;
                e2_d.write = bus.csr_result_e1_write_i;
                e2_d.wdata = bus.csr_result_e1_wdata_i;
                e2_d.exc   = bus.csr_result_e1_exception_i;
            end
        end
    end

    // E2 -> WB merge: E1 exception first, then LSU fault, then interrupt.
    always_comb begin
        exc_m   = e2_q.exc;
        addr_m  = 32'd0;
        write_m = e2_q.write;
        if (e2_q.exc != 6'd0) begin
            if (e2_fetch_fault) begin
                addr_m = e2_q.pc;
            end else if (e2_q.exc == EXC_ILLEGAL) begin
`ifdef RISCV_CSR_WB_TVAL_EN
                addr_m = e2_q.value;
`else
                addr_m = 32'd0;
`endif
            end
        end else if (bus.lsu_exception_e2_i != 6'd0) begin
            exc_m  = bus.lsu_exception_e2_i;
            addr_m = bus.lsu_addr_e2_i;
        end

        // An interrupt is taken on an instruction that is not already trapping;
        // a fence is a benign slot for it, so it is overridden as well.
        if (bus.take_interrupt_i && e2_q.valid &&
            ((exc_m == 6'd0) || (exc_m == EXC_FENCE))) begin
            exc_m   = EXC_INTERRUPT;
            addr_m  = 32'd0;
            write_m = 1'b0;
        end

        // Stall or squash loads a bubble so each instruction sits in WB once.
        wb_d = '0;
        if (e2_q.valid && !bus.stall_i && !squash) begin
            wb_d.valid = 1'b1;
            wb_d.pc    = e2_q.pc;
            wb_d.waddr = e2_q.waddr;
            wb_d.value = e2_q.value;
            wb_d.write = write_m;
            wb_d.wdata = e2_q.wdata;
            wb_d.exc   = exc_m;
            wb_d.addr  = addr_m;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e2_q <= '0;
            wb_q <= '0;
        end else begin
            e2_q <= e2_d;
            wb_q <= wb_d;
        end
    end

    assign bus.csr_writeback_write_o          = wb_q.valid & wb_q.write & (wb_q.exc == 6'd0);
    assign bus.csr_writeback_waddr_o          = wb_q.waddr;
    assign bus.csr_writeback_wdata_o          = wb_q.wdata;
    assign bus.csr_writeback_exception_o      = wb_q.exc;
    assign bus.csr_writeback_exception_pc_o   = wb_q.pc;
    assign bus.csr_writeback_exception_addr_o = wb_q.addr;
    assign bus.writeback_valid_o              = wb_q.valid & wb_q.write & (wb_q.exc == 6'd0);
    assign bus.writeback_value_o              = wb_q.value;
    assign bus.squash_o                       = squash;

    // Hold off interrupts while a CSR update or trap is still in flight.
    assign bus.interrupt_inhibit_o =
        (e2_q.valid & (e2_q.write | (e2_q.exc != 6'd0))) |
        (wb_q.valid & (wb_q.write | (wb_q.exc != 6'd0)));
endmodule

// File: tb/tb_riscv_csr_writeback.sv
module tb_riscv_csr_writeback;
    localparam logic [5:0] EXC_ILLEGAL    = 6'h12;
    localparam logic [5:0] EXC_FAULT_LOAD = 6'h15;
    localparam logic [5:0] EXC_INTERRUPT  = 6'h20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_csr_writeback_if bus();

    riscv_csr_writeback dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        wr;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [31:0] value;
        logic [5:0]  exc;
        logic [31:0] pc;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] opc, input logic [31:0] pc,
                         input logic [31:0] val, input logic wr, input logic [31:0] wd,
                         input logic [5:0] exc, input logic [5:0] lsu, input logic [31:0] la,
                         input logic ti, input logic st);
        @(posedge clk);
        #1;
        bus.opcode_valid_e1_i         = v;
        bus.opcode_opcode_e1_i        = opc;
        bus.opcode_pc_e1_i            = pc;
        bus.csr_result_e1_value_i     = val;
        bus.csr_result_e1_write_i     = wr;
        bus.csr_result_e1_wdata_i     = wd;
        bus.csr_result_e1_exception_i = exc;
        bus.lsu_exception_e2_i        = lsu;
        bus.lsu_addr_e2_i             = la;
        bus.take_interrupt_i          = ti;
        bus.stall_i                   = st;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0, 6'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Simple CSR write issued from E1; expected commit is queued at issue time.
    task automatic csr_write(input logic [11:0] a, input logic [31:0] pc,
                             input logic [31:0] val, input logic [31:0] wd, input logic exp_commit);
        exp_t e;
        drive(1'b1, {a, 20'h01073}, pc, val, 1'b1, wd, 6'd0, 6'd0, 32'd0, 1'b0, 1'b0);
        if (exp_commit) begin
            e = '{wr: 1'b1, waddr: a, wdata: wd, value: val, exc: 6'd0, pc: pc, addr: 32'd0};
            sb.push_back(e);
        end
    endtask

    task automatic push_trap(input logic [5:0] exc, input logic [31:0] pc, input logic [31:0] addr);
        exp_t e;
        e = '{wr: 1'b0, waddr: 12'd0, wdata: 32'd0, value: 32'd0, exc: exc, pc: pc, addr: addr};
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_write"},  32'(bus.csr_writeback_write_o), 32'd0);
        chk({tag, "_waddr"},  32'(bus.csr_writeback_waddr_o), 32'd0);
        chk({tag, "_wdata"},  bus.csr_writeback_wdata_o, 32'd0);
        chk({tag, "_exc"},    32'(bus.csr_writeback_exception_o), 32'd0);
        chk({tag, "_pc"},     bus.csr_writeback_exception_pc_o, 32'd0);
        chk({tag, "_addr"},   bus.csr_writeback_exception_addr_o, 32'd0);
        chk({tag, "_wbv"},    32'(bus.writeback_valid_o), 32'd0);
        chk({tag, "_value"},  bus.writeback_value_o, 32'd0);
        chk({tag, "_squash"}, 32'(bus.squash_o), 32'd0);
        chk({tag, "_inhib"},  32'(bus.interrupt_inhibit_o), 32'd0);
    endtask

    // Output monitor: every commit or trap seen in WB must match the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.csr_writeback_write_o || bus.csr_writeback_exception_o != 6'd0)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("write",   32'(bus.csr_writeback_write_o), 32'(e.wr));
                    chk("wb_valid", 32'(bus.writeback_valid_o), 32'(e.wr));
                    chk("exc",     32'(bus.csr_writeback_exception_o), 32'(e.exc));
                    chk("squash",  32'(bus.squash_o), 32'(e.exc != 6'd0));
                    if (e.wr) begin
                        chk("waddr", 32'(bus.csr_writeback_waddr_o), 32'(e.waddr));
                        chk("wdata", bus.csr_writeback_wdata_o, e.wdata);
                        chk("value", bus.writeback_value_o, e.value);
                    end
                    if (e.exc != 6'd0) begin
                        chk("exc_pc",   bus.csr_writeback_exception_pc_o, e.pc);
                        chk("exc_addr", bus.csr_writeback_exception_addr_o, e.addr);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.opcode_valid_e1_i         = 1'b0;
        bus.opcode_opcode_e1_i        = 32'd0;
        bus.opcode_pc_e1_i            = 32'd0;
        bus.csr_result_e1_value_i     = 32'd0;
        bus.csr_result_e1_write_i     = 1'b0;
        bus.csr_result_e1_wdata_i     = 32'd0;
        bus.csr_result_e1_exception_i = 6'd0;
        bus.lsu_exception_e2_i        = 6'd0;
        bus.lsu_addr_e2_i             = 32'd0;
        bus.take_interrupt_i          = 1'b0;
        bus.stall_i                   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Basic write: two-edge latency, single-cycle commit.
        csr_write(12'h340, 32'h0000_0200, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1);
        idle(1);
        @(negedge clk);
        chk("lat_e2_write", 32'(bus.csr_writeback_write_o), 32'd0);
        idle(1);
        @(negedge clk);
        chk("lat_wb_write", 32'(bus.csr_writeback_write_o), 32'd1);
        idle(3);

        // Back-to-back writes commit in order.
        csr_write(12'h341, 32'h0000_0300, 32'hA000_0001, 32'h0000_0001, 1'b1);
        csr_write(12'h342, 32'h0000_0304, 32'hA000_0002, 32'h0000_0002, 1'b1);
        csr_write(12'h343, 32'h0000_0308, 32'hA000_0003, 32'h0000_0003, 1'b1);
        idle(4);

        // Illegal instruction followed by writes that must be squashed.
        drive(1'b1, 32'h3020_0073, 32'h8000_0010, 32'h3020_0073, 1'b0, 32'd0,
              EXC_ILLEGAL, 6'd0, 32'd0, 1'b0, 1'b0);
`ifdef RISCV_CSR_WB_TVAL_EN
        push_trap(EXC_ILLEGAL, 32'h8000_0010, 32'h3020_0073);
`else
        push_trap(EXC_ILLEGAL, 32'h8000_0010, 32'd0);
`endif
        csr_write(12'h300, 32'h8000_0014, 32'h5555_0000, 32'h0000_0088, 1'b0);
        csr_write(12'h304, 32'h8000_0018, 32'h5555_0001, 32'h0000_0800, 1'b0);
        idle(4);

        // Load fault reported in E2.
        drive(1'b1, 32'h0000_2003, 32'h0000_0100, 32'd0, 1'b0, 32'd0, 6'd0, 6'd0, 32'd0, 1'b0, 1'b0);
        push_trap(EXC_FAULT_LOAD, 32'h0000_0100, 32'h8000_1003);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0, EXC_FAULT_LOAD, 32'h8000_1003, 1'b0, 1'b0);
        idle(4);

        // Interrupt lands on a CSR write in E2.
        csr_write(12'h305, 32'h0000_0400, 32'h0000_0000, 32'h0000_1234, 1'b0);
        push_trap(EXC_INTERRUPT, 32'h0000_0400, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0, 6'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("inhibit_e2", 32'(bus.interrupt_inhibit_o), 32'd1);
        idle(4);

        // Stall three cycles with a write held in E2.
        csr_write(12'h344, 32'h0000_0500, 32'h7777_0000, 32'hCAFE_F00D, 1'b1);
        repeat (3) begin
            drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0, 6'd0, 32'd0, 1'b0, 1'b1);
            @(negedge clk);
            chk("stall_bubble", 32'(bus.csr_writeback_write_o), 32'd0);
        end
        idle(4);

        // Asynchronous reset with entries in E2 and WB discards both.
        csr_write(12'h345, 32'h0000_0600, 32'h0000_AAAA, 32'h0000_AAAA, 1'b0);
        csr_write(12'h346, 32'h0000_0604, 32'h0000_BBBB, 32'h0000_BBBB, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_pre_write", 32'(bus.csr_writeback_write_o), 32'd1);
        chk("rst_pre_inhib", 32'(bus.interrupt_inhibit_o), 32'd1);
        bus.opcode_valid_e1_i     = 1'b0;
        bus.csr_result_e1_write_i = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
